decode_stage: RTL and testbench

//  RV32I instruction-decode / operand-fetch pipeline stage, directly upstream of the register file.
//  - Takes fetched {instr, pc} over a valid/ready handshake.
//  - Drives the regfile read addresses (rs1/rs2) combinationally and receives rs1_val/rs2_val back.
//  - Bypasses same-cycle writeback data, builds the immediate, and registers the decoded bundle
//    for the execute stage: one-entry pipeline register, 1-cycle latency.

---
 rtl/decode_stage.sv | 122 ++++++++++++
 tb/tb_decode_stage.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_stage.sv
// RV32I decode / operand-fetch stage: drives regfile read addresses, bypasses same-cycle
// writeback data, builds the immediate and holds one decoded bundle for execute.
module decode_stage #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  input  logic            flush,
  output logic [4:0]      rs1,
  output logic [4:0]      rs2,
  input  logic [XLEN-1:0] rs1_val,
  input  logic [XLEN-1:0] rs2_val,
  input  logic            wb_we,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_val,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [6:0]      out_opcode,
  output logic [2:0]      out_funct3,
  output logic            out_funct7b5,
  output logic [4:0]      out_rd,
  output logic            out_rd_we,
  output logic [XLEN-1:0] out_op_a,
  output logic [XLEN-1:0] out_op_b,
  output logic [XLEN-1:0] out_imm,
  output logic            out_illegal
);

  localparam logic [6:0] OP_LOAD   = 7'h03;
  localparam logic [6:0] OP_IMM    = 7'h13;
  localparam logic [6:0] OP_AUIPC  = 7'h17;
  localparam logic [6:0] OP_STORE  = 7'h23;
  localparam logic [6:0] OP_REG    = 7'h33;
  localparam logic [6:0] OP_LUI    = 7'h37;
  localparam logic [6:0] OP_BRANCH = 7'h63;
  localparam logic [6:0] OP_JALR   = 7'h67;
  localparam logic [6:0] OP_JAL    = 7'h6F;

  // Handshake: a transfer happens on an edge where valid & ready are both high.
  // Upstream: in_ready = !out_valid | out_ready. Downstream: the bundle stays
  // stable while out_valid & !out_ready. flush kills both held and incoming bundles.
  logic            capture;
  logic [6:0]      opcode;
  logic [4:0]      rd;
  logic [XLEN-1:0] imm_d;
  logic            legal_d;
  logic            writes_d;
  logic [XLEN-1:0] op_a_d;
  logic [XLEN-1:0] op_b_d;

  assign opcode   = in_instr[6:0];
  assign rd       = in_instr[11:7];
  assign rs1      = in_instr[19:15];
  assign rs2      = in_instr[24:20];
  assign in_ready = !out_valid || out_ready;
  assign capture  = in_valid && in_ready && !flush;

  // The regfile writes on this same edge, so its read port still shows the old value.
  assign op_a_d = (wb_we && wb_rd != 5'd0 && wb_rd == rs1) ? wb_val : rs1_val;
  assign op_b_d = (wb_we && wb_rd != 5'd0 && wb_rd == rs2) ? wb_val : rs2_val;

  always_comb begin
    imm_d    = '0;
    legal_d  = 1'b1;
    writes_d = 1'b0;
    case (opcode)
      OP_LOAD, OP_IMM, OP_JALR: begin
        imm_d    = {{20{in_instr[31]}}, in_instr[31:20]};
        writes_d = 1'b1;
      end
      OP_STORE:  imm_d = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
      OP_BRANCH: imm_d = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                          in_instr[30:25], in_instr[11:8], 1'b0};
      OP_LUI, OP_AUIPC: begin
        imm_d    = {in_instr[31:12], 12'b0};
        writes_d = 1'b1;
      end
      OP_JAL: begin
        imm_d    = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                    in_instr[20], in_instr[30:21], 1'b0};
        writes_d = 1'b1;
      end
      OP_REG:  writes_d = 1'b1;
      default: legal_d  = 1'b0;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst || (!capture && (flush || out_ready))) begin
      out_valid    <= 1'b0;
      out_pc       <= RESET_PC;
      out_opcode   <= '0;
      out_funct3   <= '0;
      out_funct7b5 <= 1'b0;
      out_rd       <= '0;
      out_rd_we    <= 1'b0;
      out_op_a     <= '0;
      out_op_b     <= '0;
      out_imm      <= '0;
      out_illegal  <= 1'b0;
    end else if (capture) begin
      out_valid    <= 1'b1;
      out_pc       <= in_pc;
      out_opcode   <= opcode;
      out_funct3   <= in_instr[14:12];
      out_funct7b5 <= in_instr[30];
      out_rd       <= rd;
      out_rd_we    <= writes_d && (rd != 5'd0);
      out_op_a     <= op_a_d;
      out_op_b     <= op_b_d;
      out_imm      <= imm_d;
      out_illegal  <= !legal_d;
    end
  end

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: a queue-based reference model checked every cycle,
// plus hand-computed literal expectations for the documented scenarios.
module tb_decode_stage;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] in_pc;
  logic        flush;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [31:0] rs1_val;
  logic [31:0] rs2_val;
  logic        wb_we;
  logic [4:0]  wb_rd;
  logic [31:0] wb_val;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [6:0]  out_opcode;
  logic [2:0]  out_funct3;
  logic        out_funct7b5;
  logic [4:0]  out_rd;
  logic        out_rd_we;
  logic [31:0] out_op_a;
  logic [31:0] out_op_b;
  logic [31:0] out_imm;
  logic        out_illegal;

  decode_stage #(.XLEN(32), .RESET_PC(32'h0)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .flush(flush), .rs1(rs1), .rs2(rs2),
    .rs1_val(rs1_val), .rs2_val(rs2_val), .wb_we(wb_we), .wb_rd(wb_rd), .wb_val(wb_val),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_opcode(out_opcode),
    .out_funct3(out_funct3), .out_funct7b5(out_funct7b5), .out_rd(out_rd),
    .out_rd_we(out_rd_we), .out_op_a(out_op_a), .out_op_b(out_op_b), .out_imm(out_imm),
    .out_illegal(out_illegal)
  );

  // clock / reset
  always #5 i_clk = ~i_clk;

  typedef struct packed {
    logic [31:0] pc;
    logic [6:0]  opcode;
    logic [2:0]  f3;
    logic        f7;
    logic [4:0]  rd;
    logic        rd_we;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [31:0] imm;
    logic        ill;
  } bundle_t;

  bundle_t exp_q[$];
  int      n_chk  = 0;
  int      n_pass = 0;
  bit      cmp_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Immediate from the ISA bit layouts, built with arithmetic shifts and masks.
  function automatic logic [31:0] imm_of(input logic [31:0] i);
    logic signed [31:0] s;
    s = $signed(i);
    case (i[6:0])
      7'h03, 7'h13, 7'h67: return 32'(s >>> 20);
      7'h23: return (32'(s >>> 20) & ~32'h1F) | {27'b0, i[11:7]};
      7'h63: return (32'(s >>> 19) & ~32'hFFF) | (32'(i[7]) << 11)
                  | (32'(i[30:25]) << 5) | (32'(i[11:8]) << 1);
      7'h37, 7'h17: return i & 32'hFFFF_F000;
      7'h6F: return (32'(s >>> 11) & ~32'h000F_FFFF) | (i & 32'h000F_F000)
                  | (32'(i[20]) << 11) | (32'(i[30:21]) << 1);
      default: return 32'h0;
    endcase
  endfunction

  function automatic bundle_t model_decode(input logic [31:0] i, input logic [31:0] pc,
                                           input logic [31:0] a, input logic [31:0] b,
                                           input logic we, input logic [4:0] wrd,
                                           input logic [31:0] wv);
    bundle_t r;
    logic    legal;
    legal    = i[6:0] inside {7'h03, 7'h13, 7'h33, 7'h37, 7'h17, 7'h6F, 7'h67, 7'h23, 7'h63};
    r.pc     = pc;
    r.opcode = i[6:0];
    r.f3     = i[14:12];
    r.f7     = i[30];
    r.rd     = i[11:7];
    r.rd_we  = legal && !(i[6:0] inside {7'h23, 7'h63}) && (i[11:7] != 5'd0);
    r.op_a   = (we && wrd != 5'd0 && wrd == i[19:15]) ? wv : a;
    r.op_b   = (we && wrd != 5'd0 && wrd == i[24:20]) ? wv : b;
    r.imm    = legal ? imm_of(i) : 32'h0;
    r.ill    = !legal;
    return r;
  endfunction

  // Reference model: the stage is a queue of at most one pending bundle.
  always @(posedge i_clk) begin
    bit can_take;
    if (i_rst) begin
      exp_q.delete();
    end else begin
      can_take = (exp_q.size() == 0) || out_ready;
      if (flush) begin
        exp_q.delete();
      end else begin
        if (exp_q.size() != 0 && out_ready) void'(exp_q.pop_front());
        if (in_valid && can_take)
          exp_q.push_back(model_decode(in_instr, in_pc, rs1_val, rs2_val, wb_we, wb_rd, wb_val));
      end
    end
  end

  // Compare process, away from the active edge.
  always @(negedge i_clk) begin
    if (cmp_en) begin
      chk("out_valid", 32'(out_valid), 32'(exp_q.size() != 0));
      chk("in_ready", 32'(in_ready), 32'((exp_q.size() == 0) || out_ready));
      chk("rs1", 32'(rs1), 32'(in_instr[19:15]));
      chk("rs2", 32'(rs2), 32'(in_instr[24:20]));
      if (exp_q.size() != 0) begin
        chk("out_pc", out_pc, exp_q[0].pc);
        chk("out_opcode", 32'(out_opcode), 32'(exp_q[0].opcode));
        chk("out_funct3", 32'(out_funct3), 32'(exp_q[0].f3));
        chk("out_funct7b5", 32'(out_funct7b5), 32'(exp_q[0].f7));
        chk("out_rd", 32'(out_rd), 32'(exp_q[0].rd));
        chk("out_rd_we", 32'(out_rd_we), 32'(exp_q[0].rd_we));
        chk("out_op_a", out_op_a, exp_q[0].op_a);
        chk("out_op_b", out_op_b, exp_q[0].op_b);
        chk("out_imm", out_imm, exp_q[0].imm);
        chk("out_illegal", 32'(out_illegal), 32'(exp_q[0].ill));
      end else begin
        chk("idle_out_pc", out_pc, 32'h0);
      end
    end
  end

  // driver tasks
  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic send(input logic [31:0] instr, input logic [31:0] pc);
    in_valid = 1'b1;
    in_instr = instr;
    in_pc    = pc;
    step();
  endtask

  initial begin
    i_rst = 1'b1; in_valid = 1'b1; in_instr = 32'h0050_0093; in_pc = 32'h10;
    flush = 1'b0; rs1_val = 32'h0; rs2_val = 32'h0; wb_we = 1'b0; wb_rd = 5'd0;
    wb_val = 32'h0; out_ready = 1'b1;

    // Reset held two cycles with in_valid high
    step();
    cmp_en = 1'b1;
    step();
    chk("rst_valid", 32'(out_valid), 32'h0);
    chk("rst_pc", out_pc, 32'h0);
    chk("rst_imm", out_imm, 32'h0);
    chk("rst_in_ready", 32'(in_ready), 32'h1);
    i_rst = 1'b0;

    // I-type and load
    send(32'h0050_0093, 32'h10);
    chk("addi_valid", 32'(out_valid), 32'h1);
    chk("addi_rd", 32'(out_rd), 32'h1);
    chk("addi_rd_we", 32'(out_rd_we), 32'h1);
    chk("addi_imm", out_imm, 32'h5);
    chk("addi_pc", out_pc, 32'h10);
    send(32'hFFC0_A103, 32'h14);
    chk("lw_imm", out_imm, 32'hFFFF_FFFC);
    chk("lw_funct3", 32'(out_funct3), 32'h2);
    chk("lw_rd", 32'(out_rd), 32'h2);

    // Store, illegal opcodes
    in_instr = 32'h0030_A423; in_pc = 32'h18;
    #1;
    chk("sw_rs1", 32'(rs1), 32'h1);
    chk("sw_rs2", 32'(rs2), 32'h3);
    step();
    chk("sw_imm", out_imm, 32'h8);
    chk("sw_rd_we", 32'(out_rd_we), 32'h0);
    send(32'hFFFF_FFFF, 32'h1C);
    chk("ill_flag", 32'(out_illegal), 32'h1);
    chk("ill_rd_we", 32'(out_rd_we), 32'h0);
    chk("ill_imm", out_imm, 32'h0);
    send(32'h0000_000F, 32'h20);
    chk("fence_ill", 32'(out_illegal), 32'h1);
    send(32'h0000_0073, 32'h24);
    chk("system_ill", 32'(out_illegal), 32'h1);

    // U / J / B / jalr immediates
    send(32'h1234_5537, 32'h28);
    chk("lui_imm", out_imm, 32'h1234_5000);
    send(32'h0000_1517, 32'h2C);
    chk("auipc_imm", out_imm, 32'h0000_1000);
    send(32'hFF5F_F0EF, 32'h30);
    chk("jal_imm", out_imm, 32'hFFFF_FFF4);
    chk("jal_rd_we", 32'(out_rd_we), 32'h1);
    send(32'h0020_8863, 32'h34);
    chk("beq_imm", out_imm, 32'h10);
    chk("beq_rd_we", 32'(out_rd_we), 32'h0);
    send(32'h8000_80E7, 32'h38);
    chk("jalr_imm", out_imm, 32'hFFFF_F800);

    // Bypass: add x5,x1,x2
    rs1_val = 32'h11; rs2_val = 32'h22; wb_we = 1'b1; wb_rd = 5'd1; wb_val = 32'hAA;
    send(32'h0020_82B3, 32'h3C);
    chk("byp_a", out_op_a, 32'hAA);
    chk("byp_b", out_op_b, 32'h22);
    wb_rd = 5'd0;
    send(32'h0020_82B3, 32'h40);
    chk("byp_x0_a", out_op_a, 32'h11);
    wb_rd = 5'd2; wb_val = 32'hBB;
    send(32'h0020_82B3, 32'h44);
    chk("byp_b2", out_op_b, 32'hBB);
    chk("byp_b2_a", out_op_a, 32'h11);
    wb_we = 1'b0; wb_rd = 5'd1;
    send(32'h0020_82B3, 32'h48);
    chk("byp_off_a", out_op_a, 32'h11);
    send(32'h0020_8033, 32'h4C);
    chk("rd0_rd_we", 32'(out_rd_we), 32'h0);

    // Backpressure: held bundle stays put, later writebacks do not refresh it
    out_ready = 1'b0; in_instr = 32'h00A0_0193; in_pc = 32'h50;
    for (int k = 0; k < 3; k++) begin
      wb_we = 1'b1; wb_rd = 5'd1; wb_val = 32'h100 + k; rs1_val = 32'h200 + k;
      #1;
      chk("bp_in_ready", 32'(in_ready), 32'h0);
      step();
      chk("bp_hold_pc", out_pc, 32'h4C);
      chk("bp_hold_a", out_op_a, 32'h11);
    end
    wb_we = 1'b0;
    out_ready = 1'b1;
    #1;
    chk("bp_release_ready", 32'(in_ready), 32'h1);
    step();
    chk("bp_next_pc", out_pc, 32'h50);
    chk("bp_next_imm", out_imm, 32'hA);

    // Flush with valid held and valid incoming
    flush = 1'b1;
    send(32'h0010_0113, 32'h54);
    chk("flush_valid", 32'(out_valid), 32'h0);
    chk("flush_pc", out_pc, 32'h0);
    flush = 1'b0; in_valid = 1'b0;
    step();
    chk("flush_dropped", 32'(out_valid), 32'h0);

    // Flush under backpressure
    send(32'h0010_0113, 32'h58);
    out_ready = 1'b0; flush = 1'b1;
    send(32'h0020_0113, 32'h5C);
    chk("flush_bp_valid", 32'(out_valid), 32'h0);
    flush = 1'b0; out_ready = 1'b1;

    // Reset overrides capture
    send(32'h0030_0113, 32'h60);
    i_rst = 1'b1;
    send(32'h0040_0113, 32'h64);
    chk("rst_mid_valid", 32'(out_valid), 32'h0);
    chk("rst_mid_pc", out_pc, 32'h0);
    i_rst = 1'b0; in_valid = 1'b0;
    step();
    step();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
